opendap_ap_mux: RTL and testbench

// Sits between the SW-DP's AP port and up to N_APS access ports. It shares that port

---
 rtl/opendap_ap_mux.sv | 148 ++++++++++++++
 tb/tb_opendap_ap_mux.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opendap_ap_mux.sv
// rtl/opendap_ap_mux.sv - AP port multiplexer between the SW-DP and its access ports
//
// Shares the DP's single AP port between N_APS downstream access ports. A
// request is decoded by APSEL and forwarded combinationally to one AP. The
// in-flight AP is remembered until it completes. Read data is then held for
// the DP. Unmapped APSELs read as zero and ignore writes. Aborts go to the
// in-flight AP. An optional timeout force-completes a hung AP with an error.
//
// Ports:
//   swclk, rst_n             DP clock, asynchronous active-low reset
//   up_sel/up_addr/up_wdata  request from the DP (sel/addr valid on request cycle)
//   up_wen/up_ren            write/read request pulses
//   up_abort                 DAPABORT from the DP
//   up_rdata/up_rdy/up_err   response to the DP
//   dn_addr/dn_wdata         address and write data broadcast to all APs
//   dn_wen/dn_ren/dn_abort   one-hot per-AP request and abort strobes
//   dn_rdata/dn_rdy/dn_err   per-AP response, AP i at bit i / [32*i +: 32]
//   tmo_pulse                one-cycle pulse when a timeout completes a transfer

module opendap_ap_mux #(
  parameter int N_APS   = 4,
  parameter int TIMEOUT = 0,
  parameter int W_TMO   = 16
) (
  input  logic                  swclk,
  input  logic                  rst_n,
  input  logic [7:0]            up_sel,
  input  logic [5:0]            up_addr,
  input  logic [31:0]           up_wdata,
  input  logic                  up_wen,
  input  logic                  up_ren,
  input  logic                  up_abort,
  output logic [31:0]           up_rdata,
  output logic                  up_rdy,
  output logic                  up_err,
  output logic [5:0]            dn_addr,
  output logic [31:0]           dn_wdata,
  output logic [N_APS-1:0]      dn_wen,
  output logic [N_APS-1:0]      dn_ren,
  output logic [N_APS-1:0]      dn_abort,
  input  logic [32*N_APS-1:0]   dn_rdata,
  input  logic [N_APS-1:0]      dn_rdy,
  input  logic [N_APS-1:0]      dn_err,
  output logic                  tmo_pulse
);

  localparam int SEL_W = (N_APS > 1) ? $clog2(N_APS) : 1;
  // Counter value seen on the last BUSY cycle before the forced completion.
  localparam logic [W_TMO-1:0] TMO_LAST = (TIMEOUT > 0) ? W_TMO'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cur_sel, cur_sel_nxt;
  logic [31:0]       rdata_q, rdata_q_nxt;
  logic [W_TMO-1:0]  tmo_cnt, tmo_cnt_nxt;

  logic              busy, req, mapped, accept, fwd, tmo_hit;
  logic              cur_rdy, cur_err;
  logic [31:0]       cur_rdata;
  logic [N_APS-1:0]  cur_oh, sel_oh;

  // Response of the in-flight AP and one-hot decodes of the current and requested APSEL.
  always_comb begin : ap_select
    cur_rdy   = 1'b0;
    cur_err   = 1'b0;
    cur_rdata = '0;
    cur_oh    = '0;
    sel_oh    = '0;
    for (int i = 0; i < N_APS; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        cur_rdy   = dn_rdy[i];
        cur_err   = dn_err[i];
        cur_rdata = dn_rdata[32*i +: 32];
        cur_oh[i] = 1'b1;
      end
      if (up_sel == 8'(i)) begin
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign busy   = (state == BUSY);
  assign req    = up_wen | up_ren;
  assign mapped = (up_sel < 8'(N_APS));
  // A new request is taken when idle or when the in-flight AP completes this cycle.
  // An abort in the same cycle always drops the request.
  assign accept = req && !up_abort && (!busy || cur_rdy);
  assign fwd    = accept && mapped;
  assign tmo_hit = (TIMEOUT > 0) && busy && !cur_rdy && (tmo_cnt == TMO_LAST);

  assign dn_addr   = up_addr;
  assign dn_wdata  = up_wdata;
  assign dn_wen    = (fwd && up_wen) ? sel_oh : '0;
  assign dn_ren    = (fwd && up_ren) ? sel_oh : '0;
  // A completing AP never sees an abort, even when DAPABORT coincides with its ready.
  assign dn_abort  = (busy && !cur_rdy && (up_abort || tmo_hit)) ? cur_oh : '0;
  assign tmo_pulse = tmo_hit;

  assign up_rdy   = busy ? (cur_rdy | tmo_hit) : 1'b1;
  assign up_err   = busy & ((cur_rdy & cur_err) | tmo_hit);
  assign up_rdata = busy ? cur_rdata : rdata_q;

  always_comb begin : next_state
    state_nxt   = state;
    cur_sel_nxt = cur_sel;
    rdata_q_nxt = rdata_q;
    tmo_cnt_nxt = tmo_cnt;

    if (busy) begin
      if (cur_rdy) begin
        rdata_q_nxt = cur_rdata;
        state_nxt   = IDLE;
      end else if (up_abort || tmo_hit) begin
        state_nxt   = IDLE;
      end else if (TIMEOUT > 0) begin
        tmo_cnt_nxt = tmo_cnt + 1'b1;
      end
    end

    // Evaluated after the completion path so a back-to-back request keeps BUSY
    // and an unmapped read overrides the data just captured.
    if (accept) begin
      if (mapped) begin
        state_nxt   = BUSY;
        cur_sel_nxt = up_sel[SEL_W-1:0];
        tmo_cnt_nxt = '0;
      end else if (up_ren) begin
        rdata_q_nxt = '0;
      end
    end
  end

  always_ff @(posedge swclk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state   <= IDLE;
      cur_sel <= '0;
      rdata_q <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_sel_nxt;
      rdata_q <= rdata_q_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_opendap_ap_mux.sv
// tb/tb_opendap_ap_mux.sv - scoreboard bench for the AP port multiplexer
`timescale 1ns/1ps

module tb_opendap_ap_mux;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic            swclk = 1'b0;
  logic            rst_n;
  logic [7:0]      up_sel;
  logic [5:0]      up_addr;
  logic [31:0]     up_wdata;
  logic            up_wen, up_ren, up_abort;
  logic [31:0]     up_rdata;
  logic            up_rdy, up_err;
  logic [5:0]      dn_addr;
  logic [31:0]     dn_wdata;
  logic [N-1:0]    dn_wen, dn_ren, dn_abort;
  logic [32*N-1:0] dn_rdata;
  logic [N-1:0]    dn_rdy, dn_err;
  logic            tmo_pulse;

  always #5 swclk = ~swclk;

  opendap_ap_mux #(.N_APS(N), .TIMEOUT(TMO), .W_TMO(16)) dut (
    .swclk(swclk), .rst_n(rst_n),
    .up_sel(up_sel), .up_addr(up_addr), .up_wdata(up_wdata),
    .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
    .up_rdata(up_rdata), .up_rdy(up_rdy), .up_err(up_err),
    .dn_addr(dn_addr), .dn_wdata(dn_wdata),
    .dn_wen(dn_wen), .dn_ren(dn_ren), .dn_abort(dn_abort),
    .dn_rdata(dn_rdata), .dn_rdy(dn_rdy), .dn_err(dn_err),
    .tmo_pulse(tmo_pulse)
  );

  // One expected transaction: forwarding masks on the request cycle, then the
  // response seen 'done' cycles later, counted from the request cycle.
  typedef struct {
    logic [N-1:0] wen_m;
    logic [N-1:0] ren_m;
    logic [N-1:0] abort_m;
    int           done;
    int           abort_cyc;
    logic         err;
    logic         tmo;
    logic         chk_data;
    logic [31:0]  data;
    logic [31:0]  hold;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] ref_q    = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor / scoreboard
  bit          mon_en = 1'b0;
  bit          active = 1'b0;
  int          mcyc   = 0;
  exp_t        cur;
  logic [31:0] hold   = '0;

  always @(negedge swclk) begin
    if (mon_en) begin
      chk("dn_addr", 32'(dn_addr), 32'(up_addr));
      chk("dn_wdata", dn_wdata, up_wdata);
      if (active) begin
        mcyc++;
        chk("dn_abort", 32'(dn_abort), (mcyc == cur.abort_cyc) ? 32'(cur.abort_m) : 32'd0);
        chk("tmo_pulse", 32'(tmo_pulse), 32'(mcyc == cur.done && cur.tmo));
        if (mcyc < cur.done) begin
          chk("up_rdy_busy", 32'(up_rdy), 32'd0);
        end else begin
          chk("up_rdy_done", 32'(up_rdy), 32'd1);
          chk("up_err_done", 32'(up_err), 32'(cur.err));
          if (cur.chk_data) chk("up_rdata_done", up_rdata, cur.data);
          hold   = cur.hold;
          active = 1'b0;
        end
      end else begin
        chk("up_rdy_idle", 32'(up_rdy), 32'd1);
        chk("up_err_idle", 32'(up_err), 32'd0);
        chk("up_rdata_idle", up_rdata, hold);
        chk("dn_abort_idle", 32'(dn_abort), 32'd0);
        chk("tmo_pulse_idle", 32'(tmo_pulse), 32'd0);
      end
      if (up_wen || up_ren) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_request", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("dn_wen_req", 32'(dn_wen), 32'(cur.wen_m));
          chk("dn_ren_req", 32'(dn_ren), 32'(cur.ren_m));
          active = 1'b1;
          mcyc   = 0;
        end
      end else begin
        chk("dn_wen_quiet", 32'(dn_wen), 32'd0);
        chk("dn_ren_quiet", 32'(dn_ren), 32'd0);
      end
    end
  end

  task automatic rand_aps();
    dn_rdy   = N'($urandom);
    dn_err   = N'($urandom);
    for (int i = 0; i < N; i++) dn_rdata[32*i +: 32] = $urandom;
    up_addr  = 6'($urandom);
    up_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_aps();
      up_sel   = 8'($urandom);
      up_abort = ($urandom_range(0, 3) == 0);
      @(posedge swclk); #1;
    end
    up_abort = 1'b0;
  endtask

  // Reference model: outcome of one isolated transaction, from the mux's rules.
  // abort_at < 0 means no abort; lat is the number of not-ready cycles the AP shows.
  task automatic do_txn(input bit wr, input logic [7:0] sel, input int lat, input int abort_at,
                        input logic [31:0] data, input logic err);
    exp_t         e;
    bit           mapped;
    int           s;
    logic [N-1:0] oh;
    mapped = (sel < N);
    s      = int'(sel);
    oh     = '0;
    if (mapped) oh[s] = 1'b1;
    e.wen_m     = wr ? oh : '0;
    e.ren_m     = wr ? '0 : oh;
    e.abort_m   = oh;
    e.abort_cyc = 0;
    e.err       = 1'b0;
    e.tmo       = 1'b0;
    e.chk_data  = 1'b1;
    if (!mapped) begin
      e.done = 1;
      e.data = wr ? ref_q : 32'd0;
    end else if (abort_at >= 1 && abort_at <= lat && abort_at < TMO) begin
      e.done      = abort_at + 1;
      e.abort_cyc = abort_at;
      e.data      = ref_q;
    end else if (lat >= TMO) begin
      e.done      = TMO;
      e.abort_cyc = TMO;
      e.err       = 1'b1;
      e.tmo       = 1'b1;
      e.chk_data  = 1'b0;
      e.data      = ref_q;
    end else begin
      e.done = lat + 1;
      e.err  = err;
      e.data = data;
    end
    ref_q  = e.data;
    e.hold = ref_q;
    exp_q.push_back(e);

    for (int c = 0; c <= e.done; c++) begin
      rand_aps();
      up_wen   = (c == 0) && wr;
      up_ren   = (c == 0) && !wr;
      up_sel   = (c == 0) ? sel : 8'($urandom);
      up_abort = (c == abort_at);
      if (mapped) begin
        dn_rdy[s] = (c > lat);
        if (c > lat) begin
          dn_rdata[32*s +: 32] = data;
          dn_err[s]            = err;
        end
      end
      @(posedge swclk); #1;
    end
    up_wen   = 1'b0;
    up_ren   = 1'b0;
    up_abort = 1'b0;
  endtask

  // AP1 read completes in the same cycle a write to AP2 is issued.
  task automatic back_to_back();
    exp_t        e1, e2;
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    e1.wen_m = 4'b0000; e1.ren_m = 4'b0010; e1.abort_m = 4'b0010;
    e1.done = 3; e1.abort_cyc = 0; e1.err = 1'b0; e1.tmo = 1'b0;
    e1.chk_data = 1'b1; e1.data = d1; e1.hold = d1;
    e2.wen_m = 4'b0100; e2.ren_m = 4'b0000; e2.abort_m = 4'b0100;
    e2.done = 2; e2.abort_cyc = 0; e2.err = 1'b0; e2.tmo = 1'b0;
    e2.chk_data = 1'b1; e2.data = d2; e2.hold = d2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    ref_q = d2;
    for (int c = 0; c <= 5; c++) begin
      rand_aps();
      dn_rdy[1] = (c >= 3);
      if (c >= 3) begin dn_rdata[63:32] = d1; dn_err[1] = 1'b0; end
      dn_rdy[2] = (c >= 5);
      if (c >= 5) begin dn_rdata[95:64] = d2; dn_err[2] = 1'b0; end
      up_ren   = (c == 0);
      up_wen   = (c == 3);
      up_sel   = (c == 0) ? 8'd1 : (c == 3) ? 8'd2 : 8'($urandom);
      up_abort = 1'b0;
      @(posedge swclk); #1;
    end
    up_wen = 1'b0;
    up_ren = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ab, a, r;
    logic [7:0]  sel;
    rst_n    = 1'b0;
    up_sel   = '0;
    up_addr  = '0;
    up_wdata = '0;
    up_wen   = 1'b0;
    up_ren   = 1'b0;
    up_abort = 1'b0;
    dn_rdata = '0;
    dn_rdy   = '1;
    dn_err   = '0;
    repeat (2) @(posedge swclk);
    #1;
    chk("reset_up_rdy", 32'(up_rdy), 32'd1);
    chk("reset_up_err", 32'(up_err), 32'd0);
    chk("reset_up_rdata", up_rdata, 32'd0);
    chk("reset_tmo_pulse", 32'(tmo_pulse), 32'd0);
    chk("reset_dn_strobes", 32'({dn_wen, dn_ren, dn_abort}), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_txn(1'b0, 8'd1, 3, -1, 32'h12345678, 1'b0);
    idle(10);
    do_txn(1'b1, 8'h05, 0, -1, $urandom, 1'b0);
    do_txn(1'b0, 8'h05, 0, -1, $urandom, 1'b0);
    idle(2);
    do_txn(1'b0, 8'd2, 2, -1, $urandom, 1'b1);
    idle(3);
    do_txn(1'b0, 8'd1, 1, -1, $urandom, 1'b0);
    do_txn(1'b0, 8'd0, 20, 4, $urandom, 1'b0);
    idle(3);
    do_txn(1'b0, 8'd3, 100, -1, $urandom, 1'b0);
    idle(3);
    do_txn(1'b0, 8'd1, 2, 3, $urandom, 1'b0);
    idle(2);
    back_to_back();
    idle(3);

    for (int t = 0; t < 40; t++) begin
      lat = $urandom_range(0, 10);
      r   = $urandom_range(0, 9);
      sel = (r == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      a   = $urandom_range(0, 9);
      ab  = -1;
      if (a < 2 && lat >= 1) ab = $urandom_range(1, (lat < 7) ? lat : 7);
      else if (a == 2 && lat <= 7) ab = lat + 1;
      do_txn(1'($urandom_range(0, 1)), sel, lat, ab, $urandom, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("no_txn_pending", 32'(active), 32'd0);

    // Reset in the middle of a transaction drops straight back to idle.
    mon_en   = 1'b0;
    dn_rdy   = 4'b0000;
    up_sel   = 8'd0;
    up_ren   = 1'b1;
    @(posedge swclk); #1;
    up_ren   = 1'b0;
    @(posedge swclk); #1;
    chk("midrst_busy", 32'(up_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_up_rdy", 32'(up_rdy), 32'd1);
    chk("midrst_up_rdata", up_rdata, 32'd0);
    chk("midrst_dn_abort", 32'(dn_abort), 32'd0);
    @(posedge swclk); #1;
    rst_n = 1'b1;
    @(posedge swclk); #1;
    chk("postrst_up_rdy", 32'(up_rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
